// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Holds the FSM state enum, supported opcodes, ALU operation codes,
// datapath mux-select encodings and the immediate-format helper.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StTrap
    } state_t;

    // Supported opcodes
    localparam logic [6:0] OpRAlu   = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLw     = 7'b0000011;
    localparam logic [6:0] OpSw     = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    // ALU operation codes
    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;
    localparam logic [3:0] AluXor = 4'b0100;
    localparam logic [3:0] AluSlt = 4'b0101;
    localparam logic [3:0] AluSll = 4'b0110;
    localparam logic [3:0] AluSrl = 4'b0111;
    localparam logic [3:0] AluSra = 4'b1000;

    // Operation class requested from the ALU decoder
    typedef enum logic [1:0] {
        AluOpAdd,
        AluOpSub,
        AluOpFunct
    } alu_op_t;

    // Mux selects
    localparam logic [1:0] SrcAPc     = 2'b00;
    localparam logic [1:0] SrcAOldPc  = 2'b01;
    localparam logic [1:0] SrcAReg    = 2'b10;
    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBImm    = 2'b01;
    localparam logic [1:0] SrcBFour   = 2'b10;
    localparam logic [1:0] ResAluOut  = 2'b00;
    localparam logic [1:0] ResMdr     = 2'b01;
    localparam logic [1:0] ResAlu     = 2'b10;
    localparam logic [2:0] ImmI       = 3'b000;
    localparam logic [2:0] ImmS       = 3'b001;
    localparam logic [2:0] ImmB       = 3'b010;
    localparam logic [2:0] ImmJ       = 3'b011;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] r;
        r = ImmI;
        if (op == OpSw)          r = ImmS;
        else if (op == OpBranch) r = ImmB;
        else if (op == OpJal)    r = ImmJ;
        return r;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control/datapath bundle of the multicycle core.
// Decode fields, ALU zero flag and memory ready flow into the control unit;
// memory request, datapath enables and mux selects flow out of it.
// master: control unit side. slave: datapath/memory side.
interface mc_control_unit_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src,
               instr_done, illegal
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src,
               instr_done, illegal
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder.
// alu_op   : forced ADD, forced SUB, or decode from funct fields
// funct3   : IR[14:12]
// funct7b5 : IR[30]; selects SUB (R-type only) and SRA over SRL
// is_rtype : instruction is R-type
// alu_ctrl : ALU operation code
module mc_alu_decoder
    import mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = AluAdd;
        unique case (alu_op)
            AluOpAdd: alu_ctrl = AluAdd;
            AluOpSub: alu_ctrl = AluSub;
            AluOpFunct: begin
                unique case (funct3)
                    3'b000:  alu_ctrl = (is_rtype && funct7b5) ? AluSub : AluAdd;
                    3'b001:  alu_ctrl = AluSll;
                    3'b010:  alu_ctrl = AluSlt;
                    3'b100:  alu_ctrl = AluXor;
                    3'b101:  alu_ctrl = funct7b5 ? AluSra : AluSrl;
                    3'b110:  alu_ctrl = AluOr;
                    3'b111:  alu_ctrl = AluAnd;
                    default: alu_ctrl = AluAdd;
                endcase
            end
            default: alu_ctrl = AluAdd;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Main control FSM of the multicycle RV32I core.
// clk   : core clock, rising edge
// rst_n : asynchronous active-low reset
// bus   : decode fields / zero / mem_ready in; memory request, datapath
//         enables, mux selects, instr_done and sticky illegal out
module mc_control_unit
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mc_control_unit_if.master  bus
);

    state_t     state_q, state_d;
    logic       illegal_q;
    alu_op_t    alu_op;
    logic [3:0] alu_ctrl;
    logic       br_ok;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, done;
    logic [1:0] src_a, src_b, res_src;
    logic [2:0] imm_src;

    mc_alu_decoder u_alu_dec (
        .alu_op   (alu_op),
        .funct3   (bus.funct3),
        .funct7b5 (bus.funct7b5),
        .is_rtype (bus.opcode == OpRAlu),
        .alu_ctrl (alu_ctrl)
    );

    // Only BEQ/BNE are supported
    assign br_ok = (bus.funct3[2:1] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == StTrap) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        adr_src   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        src_a     = SrcAPc;
        src_b     = SrcBReg;
        res_src   = ResAluOut;
        imm_src   = ImmI;
        alu_op    = AluOpAdd;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                src_b   = SrcBFour;
                res_src = ResAlu;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // Branch/jump target lands in ALUOut for later states
                src_a   = SrcAOldPc;
                src_b   = SrcBImm;
                imm_src = imm_src_of(bus.opcode);
                if (bus.opcode == OpLw || bus.opcode == OpSw) state_d = StMemAdr;
                else if (bus.opcode == OpRAlu)                state_d = StExecR;
                else if (bus.opcode == OpIAlu)                state_d = StExecI;
                else if (bus.opcode == OpBranch)              state_d = StBranch;
                else if (bus.opcode == OpJal)                 state_d = StJal;
                else                                          state_d = StTrap;
            end
            StMemAdr: begin
                src_a   = SrcAReg;
                src_b   = SrcBImm;
                state_d = (bus.opcode == OpLw) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                res_src   = ResMdr;
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    done    = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecR: begin
                src_a   = SrcAReg;
                src_b   = SrcBReg;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StExecI: begin
                src_a   = SrcAReg;
                src_b   = SrcBImm;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                src_a  = SrcAReg;
                src_b  = SrcBReg;
                alu_op = AluOpSub;
                if (br_ok) begin
                    // BEQ takes on zero, BNE (funct3[0]=1) on not-zero
                    pc_write = bus.zero ^ bus.funct3[0];
                    done     = 1'b1;
                    state_d  = StFetch;
                end else begin
                    state_d = StTrap;
                end
            end
            StJal: begin
                // PC <- ALUOut (target) while ALU forms the link OldPC+4
                pc_write = 1'b1;
                src_a    = SrcAOldPc;
                src_b    = SrcBFour;
                state_d  = StAluWb;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Every strobe is held low while reset is asserted
    always_comb begin
        bus.mem_req    = rst_n & mem_req;
        bus.mem_write  = rst_n & mem_write;
        bus.adr_src    = rst_n & adr_src;
        bus.ir_write   = rst_n & ir_write;
        bus.pc_write   = rst_n & pc_write;
        bus.reg_write  = rst_n & reg_write;
        bus.instr_done = rst_n & done;
        bus.illegal    = rst_n & illegal_q;
        bus.alu_src_a  = rst_n ? src_a   : 2'b00;
        bus.alu_src_b  = rst_n ? src_b   : 2'b00;
        bus.alu_ctrl   = rst_n ? alu_ctrl : 4'b0000;
        bus.result_src = rst_n ? res_src : 2'b00;
        bus.imm_src    = rst_n ? imm_src : 3'b000;
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle check of every control output.
module tb_mc_control_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_control_unit_if bus ();

    mc_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] A_ADD = 4'b0000;
    localparam logic [3:0] A_SUB = 4'b0001;
    localparam logic [3:0] A_SRA = 4'b1000;

    logic [20:0] obs;
    assign obs = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
                  bus.result_src, bus.imm_src, bus.instr_done, bus.illegal};

    function automatic logic [20:0] e(input logic mreq, input logic mw, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [3:0] alu, input logic [1:0] rs,
                                      input logic [2:0] imm, input logic done,
                                      input logic ill);
        return {mreq, mw, adr, irw, pcw, rw, a, b, alu, rs, imm, done, ill};
    endfunction

    task automatic chk(input string tag, input logic [20:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check outputs just after the negedge, then advance one full cycle
    task automatic cyc(input string tag, input logic [20:0] exp);
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    task automatic setin(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic rdy);
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7b5  = f7;
        bus.zero      = z;
        bus.mem_ready = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [20:0] zero_v, f_rdy, f_wait, dec_i, ex_addi, alu_wb, mem_adr;
        zero_v  = '0;
        f_rdy   = e(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, A_ADD, 2'b10, 3'b000, 0, 0);
        f_wait  = e(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, A_ADD, 2'b10, 3'b000, 0, 0);
        dec_i   = e(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, A_ADD, 2'b00, 3'b000, 0, 0);
        ex_addi = e(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, A_ADD, 2'b00, 3'b000, 0, 0);
        alu_wb  = e(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, A_ADD, 2'b00, 3'b000, 1, 0);
        mem_adr = ex_addi;

        rst_n = 1'b0;
        setin(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b1);
        #2;
        chk("reset_outputs", zero_v);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5 ; addi x2,x0,10 : done on cycles 4 and 8
        for (int i = 0; i < 2; i++) begin
            cyc("addi_fetch", f_rdy);
            cyc("addi_decode", dec_i);
            cyc("addi_exec", ex_addi);
            cyc("addi_wb", alu_wb);
        end
        // add x3,x1,x2 : done on cycle 12
        setin(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("add_fetch", f_rdy);
        cyc("add_decode", dec_i);
        cyc("add_exec", e(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, A_ADD, 2'b00, 3'b000, 0, 0));
        cyc("add_wb", alu_wb);

        // sub: R-type with funct7b5
        setin(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
        cyc("sub_fetch", f_rdy);
        cyc("sub_decode", dec_i);
        cyc("sub_exec", e(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, A_SUB, 2'b00, 3'b000, 0, 0));
        cyc("sub_wb", alu_wb);

        // I-type funct3=000 with IR[30]=1 is still ADD
        setin(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
        cyc("addi_f7_fetch", f_rdy);
        cyc("addi_f7_decode", dec_i);
        cyc("addi_f7_exec", ex_addi);
        cyc("addi_f7_wb", alu_wb);

        // srai
        setin(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b1);
        cyc("srai_fetch", f_rdy);
        cyc("srai_decode", dec_i);
        cyc("srai_exec", e(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, A_SRA, 2'b00, 3'b000, 0, 0));
        cyc("srai_wb", alu_wb);

        // lw x4,0(x0): 2 fetch waits, 3 memread waits, 10 cycles
        setin(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        cyc("lw_fetch_wait0", f_wait);
        cyc("lw_fetch_wait1", f_wait);
        bus.mem_ready = 1'b1;
        cyc("lw_fetch", f_rdy);
        cyc("lw_decode", dec_i);
        cyc("lw_memadr", mem_adr);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("lw_memread_wait", e(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, A_ADD, 2'b00, 3'b000, 0, 0));
        bus.mem_ready = 1'b1;
        cyc("lw_memread", e(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, A_ADD, 2'b00, 3'b000, 0, 0));
        cyc("lw_memwb", e(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, A_ADD, 2'b01, 3'b000, 1, 0));

        // sw
        setin(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("sw_fetch", f_rdy);
        cyc("sw_decode", e(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, A_ADD, 2'b00, 3'b001, 0, 0));
        cyc("sw_memadr", mem_adr);
        cyc("sw_memwrite", e(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, A_ADD, 2'b00, 3'b000, 1, 0));

        // beq x1,x1 (zero=1): taken
        setin(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
        cyc("beq_fetch", f_rdy);
        cyc("beq_decode", e(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, A_ADD, 2'b00, 3'b010, 0, 0));
        cyc("beq_taken", e(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, A_SUB, 2'b00, 3'b000, 1, 0));
        // bne x1,x1 (zero=1): not taken
        setin(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b1);
        cyc("bne_fetch", f_rdy);
        cyc("bne_decode", e(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, A_ADD, 2'b00, 3'b010, 0, 0));
        cyc("bne_not_taken", e(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, A_SUB, 2'b00, 3'b000, 1, 0));

        // jal x5,+16
        setin(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("jal_fetch", f_rdy);
        cyc("jal_decode", e(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, A_ADD, 2'b00, 3'b011, 0, 0));
        cyc("jal_exec", e(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, A_ADD, 2'b00, 3'b000, 0, 0));
        cyc("jal_wb", alu_wb);

        // Reset during MEMWRITE drops mem_write immediately
        setin(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        cyc("swr_fetch", f_rdy);
        cyc("swr_decode", e(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, A_ADD, 2'b00, 3'b001, 0, 0));
        cyc("swr_memadr", mem_adr);
        bus.mem_ready = 1'b0;
        #1;
        chk("swr_memwrite_wait", e(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, A_ADD, 2'b00, 3'b000, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("swr_reset_drop", zero_v);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        cyc("swr_post_reset_fetch", f_rdy);
        cyc("swr_post_reset_decode", e(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, A_ADD, 2'b00, 3'b001, 0, 0));

        // Restart cleanly, then an illegal opcode traps
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        setin(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("trap_fetch", f_rdy);
        cyc("trap_decode", dec_i);
        cyc("trap_state0", e(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, A_ADD, 2'b00, 3'b000, 0, 1));
        setin(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("trap_state1", e(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, A_ADD, 2'b00, 3'b000, 0, 1));
        rst_n = 1'b0;
        #1;
        chk("trap_reset_clears", zero_v);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("trap_post_reset_fetch", f_rdy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
